// File: rtl/instruction_decode.sv
// -----------------------------------------------------------------------------
// instruction_decode
//
// ID stage of a 5-stage 32-bit MIPS-subset pipeline. It sits between the
// IF/ID latch and the EX stage. It holds the 32x32 general purpose register
// file, decodes the opcode into WB/MEM/EX control bundles, sign-extends the
// 16-bit immediate, and registers everything into the ID/EX latch.
//
// Optional feature (compile-time macro): ID_WRITE_BYPASS_EN
//   defined   : a write-back to rs/rt in the same cycle is forwarded into
//               readData1/readData2 (write-first behaviour).
//   undefined : readData1/readData2 latch the old register contents
//               (read-first); the new value is visible one cycle later.
//
// Ports
//   clk                 in   1   system clock, all state changes on posedge
//   reset               in   1   synchronous active-high reset
//   programCounterIn    in   32  PC+4 from the IF/ID latch
//   instruction         in   32  instruction word from the IF/ID latch
//   writeRegister       in   5   write-back destination register index
//   writeData           in   32  write-back data
//   regWrite            in   1   write-back enable
//   writeBackControl    out  2   {regWrite, memToReg}
//   memAccessControl    out  3   {branch, memRead, memWrite}
//   calculationControl  out  4   {regDst, aluOp[1:0], aluSrc}
//   programCounterOut   out  32  registered programCounterIn
//   readData1           out  32  registered GPR[rs]
//   readData2           out  32  registered GPR[rt]
//   immediateOperand    out  32  registered sign-extended instruction[15:0]
//   writeRegister0      out  5   registered rt field
//   writeRegister1      out  5   registered rd field
// -----------------------------------------------------------------------------
module instruction_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] programCounterIn,
    input  logic [31:0] instruction,
    input  logic [4:0]  writeRegister,
    input  logic [31:0] writeData,
    input  logic        regWrite,
    output logic [1:0]  writeBackControl,
    output logic [2:0]  memAccessControl,
    output logic [3:0]  calculationControl,
    output logic [31:0] programCounterOut,
    output logic [31:0] readData1,
    output logic [31:0] readData2,
    output logic [31:0] immediateOperand,
    output logic [4:0]  writeRegister0,
    output logic [4:0]  writeRegister1
);

    // Supported opcodes; anything else decodes to an all-zero bubble.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // -------------------------------------------------------------------------
    // Instruction field split
    // -------------------------------------------------------------------------
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm16;

    assign op    = instruction[31:26];
    assign rs    = instruction[25:21];
    assign rt    = instruction[20:16];
    assign rd    = instruction[15:11];
    assign imm16 = instruction[15:0];

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    logic [1:0] wb_ctrl_d;
    logic [2:0] mem_ctrl_d;
    logic [3:0] ex_ctrl_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so that an
        // unlisted opcode cannot leave a path unassigned and infer a latch.
        wb_ctrl_d  = 2'b00;
        mem_ctrl_d = 3'b000;
        ex_ctrl_d  = 4'b0000;
        case (op)
            OP_RTYPE: begin
                wb_ctrl_d  = 2'b10;    // regWrite
                mem_ctrl_d = 3'b000;
                ex_ctrl_d  = 4'b1100;  // regDst, aluOp=10
            end
            OP_LW: begin
                wb_ctrl_d  = 2'b11;    // regWrite, memToReg
                mem_ctrl_d = 3'b010;   // memRead
                ex_ctrl_d  = 4'b0001;  // aluSrc, aluOp=00 (add)
            end
            OP_SW: begin
                wb_ctrl_d  = 2'b00;
                mem_ctrl_d = 3'b001;   // memWrite
                ex_ctrl_d  = 4'b0001;  // aluSrc, aluOp=00 (add)
            end
            OP_BEQ: begin
                wb_ctrl_d  = 2'b00;
                mem_ctrl_d = 3'b100;   // branch
                ex_ctrl_d  = 4'b0010;  // aluOp=01 (subtract)
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Register file
    // -------------------------------------------------------------------------
    logic [31:0] gpr_q [32];
    logic        wb_write_en;

    // Writes to register 0 are dropped so that it always reads as zero.
    assign wb_write_en = regWrite && (writeRegister != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the whole array is cleared on reset because the pipeline
            // is allowed to read any register straight after reset; this
            // forces a flop-based register file rather than a RAM macro.
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (wb_write_en) begin
            // NOTE: non-blocking assignment, so a read in this same cycle
            // still sees the old value unless the bypass path forwards it.
            gpr_q[writeRegister] <= writeData;
        end
    end

    // Combinational read ports. Index 0 is forced to zero explicitly so the
    // zero register does not depend on the write guard alone.
    logic [31:0] rs_value;
    logic [31:0] rt_value;

    always_comb begin
        rs_value = '0;
        if (rs != 5'd0) begin
            rs_value = gpr_q[rs];
        end
`ifdef ID_WRITE_BYPASS_EN
        // Forward a same-cycle write-back so the latch captures the new value.
        if (wb_write_en && (writeRegister == rs)) begin
            rs_value = writeData;
        end
`endif
    end

    always_comb begin
        rt_value = '0;
        if (rt != 5'd0) begin
            rt_value = gpr_q[rt];
        end
`ifdef ID_WRITE_BYPASS_EN
        if (wb_write_en && (writeRegister == rt)) begin
            rt_value = writeData;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Immediate sign extension
    // -------------------------------------------------------------------------
    logic [31:0] imm_ext_d;

    assign imm_ext_d = {{16{imm16[15]}}, imm16};

    // -------------------------------------------------------------------------
    // ID/EX pipeline latch
    // -------------------------------------------------------------------------
    logic [1:0]  wb_ctrl_q;
    logic [2:0]  mem_ctrl_q;
    logic [3:0]  ex_ctrl_q;
    logic [31:0] pc_q;
    logic [31:0] read_data1_q;
    logic [31:0] read_data2_q;
    logic [31:0] imm_ext_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ctrl_q    <= '0;
            mem_ctrl_q   <= '0;
            ex_ctrl_q    <= '0;
            pc_q         <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            imm_ext_q    <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
        end else begin
            wb_ctrl_q    <= wb_ctrl_d;
            mem_ctrl_q   <= mem_ctrl_d;
            ex_ctrl_q    <= ex_ctrl_d;
            pc_q         <= programCounterIn;
            read_data1_q <= rs_value;
            read_data2_q <= rt_value;
            imm_ext_q    <= imm_ext_d;
            rt_q         <= rt;
            rd_q         <= rd;
        end
    end

    assign writeBackControl   = wb_ctrl_q;
    assign memAccessControl   = mem_ctrl_q;
    assign calculationControl = ex_ctrl_q;
    assign programCounterOut  = pc_q;
    assign readData1          = read_data1_q;
    assign readData2          = read_data2_q;
    assign immediateOperand   = imm_ext_q;
    assign writeRegister0     = rt_q;
    assign writeRegister1     = rd_q;

endmodule

// File: tb/tb_instruction_decode.sv
// -----------------------------------------------------------------------------
// tb_instruction_decode
//
// Self-checking bench for instruction_decode. A reference model (register
// array plus an opcode->control lookup table) predicts every ID/EX output for
// each clock; directed steps cover the documented scenarios and a randomized
// phase follows. Compile with +define+ID_WRITE_BYPASS_EN to check the
// write-first variant.
// -----------------------------------------------------------------------------
module tb_instruction_decode;

    logic        clk;
    logic        reset;
    logic [31:0] programCounterIn;
    logic [31:0] instruction;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [1:0]  writeBackControl;
    logic [2:0]  memAccessControl;
    logic [3:0]  calculationControl;
    logic [31:0] programCounterOut;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] immediateOperand;
    logic [4:0]  writeRegister0;
    logic [4:0]  writeRegister1;

    int checks = 0;
    int errors = 0;

    instruction_decode dut (
        .clk                (clk),
        .reset              (reset),
        .programCounterIn   (programCounterIn),
        .instruction        (instruction),
        .writeRegister      (writeRegister),
        .writeData          (writeData),
        .regWrite           (regWrite),
        .writeBackControl   (writeBackControl),
        .memAccessControl   (memAccessControl),
        .calculationControl (calculationControl),
        .programCounterOut  (programCounterOut),
        .readData1          (readData1),
        .readData2          (readData2),
        .immediateOperand   (immediateOperand),
        .writeRegister0     (writeRegister0),
        .writeRegister1     (writeRegister1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] model_gpr [32];
    logic [8:0]  exp_ctrl;      // {wb[1:0], mem[2:0], ex[3:0]}
    logic [31:0] exp_pc;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_imm;
    logic [4:0]  exp_wr0;
    logic [4:0]  exp_wr1;

    // Control table as written in the opcode list.
    function automatic logic [8:0] ctrl_of(input logic [5:0] opcode);
        if (opcode == 6'h00) return 9'b10_000_1100;
        if (opcode == 6'h23) return 9'b11_010_0001;
        if (opcode == 6'h2B) return 9'b00_001_0001;
        if (opcode == 6'h04) return 9'b00_100_0010;
        return 9'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        logic [31:0] v;
        v = (idx == 5'd0) ? 32'd0 : model_gpr[idx];
`ifdef ID_WRITE_BYPASS_EN
        if (regWrite && writeRegister == idx && idx != 5'd0) v = writeData;
`endif
        return v;
    endfunction

    // Predict what the ID/EX latch captures at the coming edge and then
    // apply the same edge to the model register file.
    task automatic model_edge();
        if (reset) begin
            exp_ctrl = '0; exp_pc = '0; exp_rd1 = '0; exp_rd2 = '0;
            exp_imm  = '0; exp_wr0 = '0; exp_wr1 = '0;
            for (int i = 0; i < 32; i++) model_gpr[i] = '0;
        end else begin
            exp_ctrl = ctrl_of(instruction[31:26]);
            exp_pc   = programCounterIn;
            exp_rd1  = model_read(instruction[25:21]);
            exp_rd2  = model_read(instruction[20:16]);
            exp_imm  = 32'(signed'(instruction[15:0]));
            exp_wr0  = instruction[20:16];
            exp_wr1  = instruction[15:11];
            if (regWrite && writeRegister != 5'd0) model_gpr[writeRegister] = writeData;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge, compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("wb",   32'(writeBackControl),   32'(exp_ctrl[8:7]));
        check("mem",  32'(memAccessControl),   32'(exp_ctrl[6:4]));
        check("ex",   32'(calculationControl), 32'(exp_ctrl[3:0]));
        check("pc",   programCounterOut,       exp_pc);
        check("rd1",  readData1,               exp_rd1);
        check("rd2",  readData2,               exp_rd2);
        check("imm",  immediateOperand,        exp_imm);
        check("wr0",  32'(writeRegister0),     32'(exp_wr0));
        check("wr1",  32'(writeRegister1),     32'(exp_wr1));
    endtask

    task automatic set_in(input logic rst, input logic [31:0] pc, input logic [31:0] ins,
                          input logic we, input logic [4:0] wr, input logic [31:0] wd);
        reset = rst; programCounterIn = pc; instruction = ins;
        regWrite = we; writeRegister = wr; writeData = wd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model_gpr[i] = '0;

        // Reset for one cycle with a competing write to GPR3 that must be dropped.
        set_in(1'b1, 32'h1234_5678, 32'h8C22_FFFC, 1'b1, 5'd3, 32'hDEAD_BEEF);
        step();
        check("reset_wb",  32'(writeBackControl), 32'd0);
        check("reset_rd1", readData1, 32'd0);
        check("reset_imm", immediateOperand, 32'd0);

        // After release: rs=1, rt=2 read zero.
        set_in(1'b0, 32'd4, 32'h0022_1000, 1'b0, 5'd0, 32'd0);
        step();
        check("post_reset_rd1", readData1, 32'd0);
        check("post_reset_rd2", readData2, 32'd0);

        // GPR3 write during reset must have been dropped.
        set_in(1'b0, 32'd8, 32'h0060_0000, 1'b0, 5'd0, 32'd0);
        step();
        check("reset_drops_write", readData1, 32'd0);

        // R-type decode.
        set_in(1'b0, 32'd0, 32'b000000_00000_00001_00010_00000_000000, 1'b0, 5'd0, 32'd0);
        step();
        check("rtype_ctrl", {23'd0, writeBackControl, memAccessControl, calculationControl},
              {23'd0, 9'b10_000_1100});
        check("rtype_wr0", 32'(writeRegister0), 32'd1);
        check("rtype_wr1", 32'(writeRegister1), 32'd2);
        check("rtype_imm", immediateOperand, 32'h0000_1000);
        check("rtype_pc",  programCounterOut, 32'd0);

        // Write to GPR0 is ignored; rs=0 keeps reading zero.
        set_in(1'b0, 32'd0, 32'h0001_1000, 1'b1, 5'd0, 32'hFFFF_FFFF);
        step();
        check("gpr0_same", readData1, 32'd0);
        step();
        check("gpr0_next", readData1, 32'd0);

        // Write GPR1 while rt=1 is being read.
        set_in(1'b0, 32'd0, 32'h0001_1000, 1'b1, 5'd1, 32'hFFFF_FFFF);
        step();
`ifdef ID_WRITE_BYPASS_EN
        check("gpr1_same_cycle", readData2, 32'hFFFF_FFFF);
`else
        check("gpr1_same_cycle", readData2, 32'd0);
`endif
        regWrite = 1'b0;
        step();
        check("gpr1_next_cycle", readData2, 32'hFFFF_FFFF);
        check("gpr0_after_gpr1", readData1, 32'd0);

        // lw / sw / beq / unknown opcode.
        set_in(1'b0, 32'd16, 32'h8C22_FFFC, 1'b0, 5'd0, 32'd0);
        step();
        check("lw_ctrl", 32'({writeBackControl, memAccessControl, calculationControl}), 32'(9'b11_010_0001));
        check("lw_imm",  immediateOperand, 32'hFFFF_FFFC);
        check("lw_wr0",  32'(writeRegister0), 32'd2);

        instruction = 32'hAC22_0004;
        step();
        check("sw_ctrl", 32'({writeBackControl, memAccessControl, calculationControl}), 32'(9'b00_001_0001));

        instruction = 32'h1022_0003;
        step();
        check("beq_mem", 32'(memAccessControl), 32'b100);
        check("beq_ex",  32'(calculationControl), 32'b0010);

        instruction = 32'hFC00_0000;
        step();
        check("nop_ctrl", 32'({writeBackControl, memAccessControl, calculationControl}), 32'd0);

        // Randomized phase: mixed opcodes, write-backs, reads aimed at the
        // register being written, and occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  opc;
            logic [31:0] ins;
            logic [4:0]  wr;
            case ($urandom_range(0, 4))
                0: opc = 6'h00;
                1: opc = 6'h23;
                2: opc = 6'h2B;
                3: opc = 6'h04;
                default: opc = 6'($urandom);
            endcase
            ins = {opc, 26'($urandom)};
            wr  = 5'($urandom);
            if ($urandom_range(0, 3) == 0) ins[25:21] = wr;
            if ($urandom_range(0, 3) == 0) ins[20:16] = wr;
            set_in(($urandom_range(0, 39) == 0), $urandom, ins,
                   1'($urandom), wr, $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
